jk_excite_driver: RTL

- Write-side driver for an N-bit bank of JK flip-flops. It is the counterpart to the JK bank's J/K/Q interface.
- Accepts a target N-bit value over a valid/ready handshake. It computes per-bit J/K excitation from the bank's current Q, drives it for one clock, then reads Q back and checks that the bank reached the target.
- Retries on mismatch up to a bounded count, then reports DONE or ERR.
- Sits between control logic and any JK register bank in the design.

---
 rtl/jk_excite_driver.sv | 138 +++++++++++++
 1 files changed

// File: rtl/jk_excite_driver.sv
// jk_excite_driver: write-side driver for an N-bit JK flip-flop bank.
// It accepts a target over valid/ready, drives J/K for one cycle toward it,
// waits SETTLE cycles, compares Q back against the target, and retries up to
// MAX_RETRY times before pulsing o_done or o_err.
//
// Ports:
//   i_clk        clock, all state changes on the rising edge
//   i_clr        synchronous active-high reset, overrides everything
//   i_tgt_valid  target offered
//   o_tgt_ready  driver can accept a target (IDLE and not in reset)
//   i_tgt        target value, sampled at acceptance
//   i_q_in       current Q outputs of the JK bank
//   o_j, o_k     registered J/K excitation to the bank
//   o_busy       high in any state other than IDLE
//   o_done       one-cycle pulse, bank matched target
//   o_err        one-cycle pulse, retries exhausted without a match
module jk_excite_driver #(
  parameter int unsigned N         = 4,
  parameter int unsigned MAX_RETRY = 2,
  parameter int unsigned SETTLE    = 1
) (
  input  logic         i_clk,
  input  logic         i_clr,
  input  logic         i_tgt_valid,
  output logic         o_tgt_ready,
  input  logic [N-1:0] i_tgt,
  input  logic [N-1:0] i_q_in,
  output logic [N-1:0] o_j,
  output logic [N-1:0] o_k,
  output logic         o_busy,
  output logic         o_done,
  output logic         o_err
);

  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_WAIT  = 2'd2,
    S_CHECK = 2'd3
  } state_t;

  state_t        r_state, w_state_nx;
  logic [N-1:0]  r_tgt, w_tgt_nx;
  logic [N-1:0]  r_j, w_j_nx;
  logic [N-1:0]  r_k, w_k_nx;
  logic [CW-1:0] r_retry, w_retry_nx;
  logic [CW-1:0] r_settle, w_settle_nx;
  logic          r_done, w_done_nx;
  logic          r_err, w_err_nx;
  logic          w_accept;

  // Ready must drop in the same cycle as a clear, so it is decoded here.
  assign o_tgt_ready = (r_state == S_IDLE) && !i_clr;
  assign w_accept    = i_tgt_valid && o_tgt_ready;

  assign o_j    = r_j;
  assign o_k    = r_k;
  assign o_busy = (r_state != S_IDLE);
  assign o_done = r_done;
  assign o_err  = r_err;

  // State and output registers.
  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_state  <= S_IDLE;
      r_tgt    <= '0;
      r_j      <= '0;
      r_k      <= '0;
      r_retry  <= '0;
      r_settle <= '0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_tgt    <= w_tgt_nx;
      r_j      <= w_j_nx;
      r_k      <= w_k_nx;
      r_retry  <= w_retry_nx;
      r_settle <= w_settle_nx;
      r_done   <= w_done_nx;
      r_err    <= w_err_nx;
    end
  end

  // Next-state and next-output logic. Excitation uses J only for 0->1 and
  // K only for 1->0, so J and K are never both set on a bit.
  always_comb begin
    w_state_nx  = r_state;
    w_tgt_nx    = r_tgt;
    w_j_nx      = '0;
    w_k_nx      = '0;
    w_retry_nx  = r_retry;
    w_settle_nx = r_settle;
    w_done_nx   = 1'b0;
    w_err_nx    = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_tgt_nx   = i_tgt;
          w_j_nx     = ~i_q_in & i_tgt;
          w_k_nx     = i_q_in & ~i_tgt;
          w_retry_nx = '0;
          w_state_nx = S_DRIVE;
        end
      end
      S_DRIVE: begin
        w_settle_nx = CW'(SETTLE);
        w_state_nx  = S_WAIT;
      end
      S_WAIT: begin
        if (r_settle <= CW'(1)) begin
          w_state_nx = S_CHECK;
        end else begin
          w_settle_nx = r_settle - CW'(1);
        end
      end
      S_CHECK: begin
        if (i_q_in == r_tgt) begin
          w_done_nx  = 1'b1;
          w_state_nx = S_IDLE;
        end else if (r_retry < CW'(MAX_RETRY)) begin
          w_retry_nx = r_retry + CW'(1);
          w_j_nx     = ~i_q_in & r_tgt;
          w_k_nx     = i_q_in & ~r_tgt;
          w_state_nx = S_DRIVE;
        end else begin
          w_err_nx   = 1'b1;
          w_state_nx = S_IDLE;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

endmodule
